// File: rtl/cv_touch_emu.sv
// cv_touch_emu: turns the four CV input samples into 8-bit touch readings.
// One snapshot of all inputs is taken per rising edge of sample_clk, then the
// four channels are scaled, clamped, jack-gated and slew-limited one per cycle.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   sample_clk   frame strobe level (synchronous to clk)
//   sample_in0-3 signed CV samples, W bits
//   jack         jack-detect, bit i = input i patched (bits 3:0 used)
//   touch0-3     emulated touch readings, unsigned 8-bit (registered)
//   touch_valid  one-cycle pulse after touch3 is updated
//   overrun      sticky, a frame edge arrived while busy
module cv_touch_emu #(
  parameter int unsigned W    = 16,
  parameter int unsigned SLEW = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sample_clk,
  input  logic [W-1:0] sample_in0,
  input  logic [W-1:0] sample_in1,
  input  logic [W-1:0] sample_in2,
  input  logic [W-1:0] sample_in3,
  input  logic [7:0]   jack,
  output logic [7:0]   touch0,
  output logic [7:0]   touch1,
  output logic [7:0]   touch2,
  output logic [7:0]   touch3,
  output logic         touch_valid,
  output logic         overrun
);

  localparam int unsigned SHIFT = W - 10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CH0  = 3'd1,
    CH1  = 3'd2,
    CH2  = 3'd3,
    CH3  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic                 sc_q;
  logic [3:0][W-1:0]    snap_q, snap_d;
  logic [3:0]           jack_q, jack_d;
  logic [3:0][7:0]      touch_q, touch_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;

  logic                 frame_edge_c;
  logic [1:0]           ch_c;
  logic [7:0]           target_c;
  logic [7:0]           new_val_c;
  logic                 jack_unused_c;

  // Only four inputs exist; the upper jack bits are intentionally ignored.
  assign jack_unused_c = ^jack[7:4];

  assign frame_edge_c = sample_clk & ~sc_q;

  // Scale to the touch range: arithmetic shift to 10 bits, clamp to 0..255.
  function automatic logic [7:0] calc_target(input logic [W-1:0] smp,
                                             input logic en);
    logic signed [W-1:0] sx;
    logic signed [9:0]   s;
    sx = $signed(smp) >>> SHIFT;
    s  = 10'(sx);
    if (!en)                 return 8'd0;
    else if (s < 10'sd0)     return 8'd0;
    else if (s > 10'sd255)   return 8'd255;
    else                     return 8'(s);
  endfunction

  // Limit the step from cur toward tgt to SLEW; stays inside 0..255.
  function automatic logic [7:0] calc_slew(input logic [7:0] tgt,
                                           input logic [7:0] cur);
    logic signed [9:0] d;
    logic signed [9:0] lim;
    logic signed [9:0] r;
    lim = $signed(10'(SLEW));
    d   = $signed({2'b00, tgt}) - $signed({2'b00, cur});
    if (d > lim)       r = $signed({2'b00, cur}) + lim;
    else if (d < -lim) r = $signed({2'b00, cur}) - lim;
    else               r = $signed({2'b00, tgt});
    return 8'(r);
  endfunction

  // Channel currently being processed, derived from the state.
  always_comb begin
    ch_c = 2'd0;
    case (state_q)
      CH1:     ch_c = 2'd1;
      CH2:     ch_c = 2'd2;
      CH3:     ch_c = 2'd3;
      default: ch_c = 2'd0;
    endcase
  end

  assign target_c  = calc_target(snap_q[ch_c], jack_q[ch_c]);
  assign new_val_c = calc_slew(target_c, touch_q[ch_c]);

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    jack_d    = jack_q;
    touch_d   = touch_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (frame_edge_c) begin
          snap_d  = {sample_in3, sample_in2, sample_in1, sample_in0};
          jack_d  = jack[3:0];
          state_d = CH0;
        end
      end
      CH0: begin
        touch_d[0] = new_val_c;
        state_d    = CH1;
        if (frame_edge_c) overrun_d = 1'b1;
      end
      CH1: begin
        touch_d[1] = new_val_c;
        state_d    = CH2;
        if (frame_edge_c) overrun_d = 1'b1;
      end
      CH2: begin
        touch_d[2] = new_val_c;
        state_d    = CH3;
        if (frame_edge_c) overrun_d = 1'b1;
      end
      CH3: begin
        touch_d[3] = new_val_c;
        valid_d    = 1'b1;
        state_d    = IDLE;
        if (frame_edge_c) overrun_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sc_q      <= 1'b0;
      snap_q    <= '0;
      jack_q    <= '0;
      touch_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sc_q      <= sample_clk;
      snap_q    <= snap_d;
      jack_q    <= jack_d;
      touch_q   <= touch_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign touch0      = touch_q[0];
  assign touch1      = touch_q[1];
  assign touch2      = touch_q[2];
  assign touch3      = touch_q[3];
  assign touch_valid = valid_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_cv_touch_emu.sv
// Bench for cv_touch_emu: dut_a runs unlimited slew, dut_b runs SLEW=16.
// Expected frames are queued by the stimulus; monitors compare on touch_valid.
module tb_cv_touch_emu;

  logic        clk;
  logic        rst, rst_b;
  logic        sample_clk, sample_clk_b;
  logic [15:0] in0, in1, in2, in3;
  logic [7:0]  jack;
  logic [7:0]  ta0, ta1, ta2, ta3, tb0, tb1, tb2, tb3;
  logic        valid_a, valid_b, ovr_a, ovr_b;

  int checks = 0;
  int errors = 0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];

  cv_touch_emu #(.W(16), .SLEW(255)) dut_a (
    .clk(clk), .rst(rst), .sample_clk(sample_clk),
    .sample_in0(in0), .sample_in1(in1), .sample_in2(in2), .sample_in3(in3),
    .jack(jack), .touch0(ta0), .touch1(ta1), .touch2(ta2), .touch3(ta3),
    .touch_valid(valid_a), .overrun(ovr_a));

  cv_touch_emu #(.W(16), .SLEW(16)) dut_b (
    .clk(clk), .rst(rst_b), .sample_clk(sample_clk_b),
    .sample_in0(in0), .sample_in1(in1), .sample_in2(in2), .sample_in3(in3),
    .jack(jack), .touch0(tb0), .touch1(tb1), .touch2(tb2), .touch3(tb3),
    .touch_valid(valid_b), .overrun(ovr_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: one per DUT, triggered by touch_valid.
  always @(posedge clk) begin
    logic [31:0] e;
    #1;
    if (valid_a) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL frame_a: unexpected touch_valid, touch={%0d,%0d,%0d,%0d} at %0t",
                 ta0, ta1, ta2, ta3, $time);
      end else begin
        e = q_a.pop_front();
        if ({ta3, ta2, ta1, ta0} !== e) begin
          errors++;
          $display("FAIL frame_a: got {%0d,%0d,%0d,%0d} expected {%0d,%0d,%0d,%0d} at %0t",
                   ta0, ta1, ta2, ta3, e[7:0], e[15:8], e[23:16], e[31:24], $time);
        end
      end
    end
    if (valid_b) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL frame_b: unexpected touch_valid, touch0=%0d at %0t", tb0, $time);
      end else begin
        e = q_b.pop_front();
        if ({tb3, tb2, tb1, tb0} !== e) begin
          errors++;
          $display("FAIL frame_b: got {%0d,%0d,%0d,%0d} expected {%0d,%0d,%0d,%0d} at %0t",
                   tb0, tb1, tb2, tb3, e[7:0], e[15:8], e[23:16], e[31:24], $time);
        end
      end
    end
  end

  // One frame strobe on dut_a, then let the sequence complete.
  task automatic frame_a(input logic [31:0] exp);
    q_a.push_back(exp);
    @(negedge clk); sample_clk = 1'b1;
    @(negedge clk); sample_clk = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic frame_b(input logic [7:0] exp0);
    q_b.push_back({24'd0, exp0});
    @(negedge clk); sample_clk_b = 1'b1;
    @(negedge clk); sample_clk_b = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_b;
    rst = 1'b1; rst_b = 1'b1;
    sample_clk = 1'b0; sample_clk_b = 1'b0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0; jack = 8'h0F;

    // Reset with toggling strobe and random inputs.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sample_clk = ~sample_clk; sample_clk_b = ~sample_clk_b;
      in0 = 16'($urandom); in1 = 16'($urandom);
      in2 = 16'($urandom); in3 = 16'($urandom); jack = 8'($urandom);
    end
    @(posedge clk); #1;
    chk("rst_touch", {ta3, ta2, ta1, ta0}, 32'd0);
    chk("rst_valid", {31'd0, valid_a}, 32'd0);
    chk("rst_overrun", {31'd0, ovr_a}, 32'd0);
    @(negedge clk);
    sample_clk = 1'b0; sample_clk_b = 1'b0;
    rst = 1'b0; rst_b = 1'b0;
    repeat (6) @(posedge clk); #1;
    chk("idle_touch", {ta3, ta2, ta1, ta0}, 32'd0);
    chk("idle_overrun", {31'd0, ovr_a}, 32'd0);

    // Scaling and clamp, with latency checks.
    jack = 8'h0F;
    in0 = 16'h1000; in1 = 16'h7FFF; in2 = 16'h8000; in3 = 16'h03FF;
    q_a.push_back({8'd15, 8'd0, 8'd255, 8'd64});
    @(negedge clk); sample_clk = 1'b1;
    @(posedge clk);                              // E
    @(negedge clk); sample_clk = 1'b0;
    @(posedge clk); #1;                          // E+1
    chk("lat_touch0", {24'd0, ta0}, 32'd64);
    chk("lat_touch1", {24'd0, ta1}, 32'd0);
    chk("lat_valid_e1", {31'd0, valid_a}, 32'd0);
    @(posedge clk); @(posedge clk);
    @(posedge clk); #1;                          // E+4
    chk("lat_valid_e4", {31'd0, valid_a}, 32'd1);
    @(posedge clk); #1;                          // E+5
    chk("lat_valid_e5", {31'd0, valid_a}, 32'd0);
    repeat (2) @(posedge clk);

    // Jack gate.
    jack = 8'h05;
    in0 = 16'h2000; in1 = 16'h2000; in2 = 16'h2000; in3 = 16'h2000;
    frame_a({8'd0, 8'd128, 8'd0, 8'd128});

    // Overrun: second edge at E+2 dropped, input change after snapshot ignored.
    jack = 8'h0F;
    in0 = 16'h0800; in1 = 16'h1400; in2 = 16'h0000; in3 = 16'h4000;
    q_a.push_back({8'd255, 8'd0, 8'd80, 8'd32});
    @(negedge clk); sample_clk = 1'b1;
    @(posedge clk);                              // E
    @(negedge clk); sample_clk = 1'b0; in0 = 16'h7FFF;
    @(posedge clk); #1;                          // E+1
    chk("ovr_e1", {31'd0, ovr_a}, 32'd0);
    @(negedge clk); sample_clk = 1'b1;
    @(posedge clk); #1;                          // E+2
    chk("ovr_e2", {31'd0, ovr_a}, 32'd1);
    @(negedge clk); sample_clk = 1'b0;
    repeat (6) @(posedge clk);
    frame_a({8'd255, 8'd0, 8'd80, 8'd255});
    #1;
    chk("ovr_sticky", {31'd0, ovr_a}, 32'd1);

    // Reset mid-frame at E+2: outputs clear, no touch_valid.
    in0 = 16'h1000; in1 = 16'h2000; in2 = 16'h2000; in3 = 16'h2000;
    @(negedge clk); sample_clk = 1'b1;
    @(posedge clk);                              // E
    @(negedge clk); sample_clk = 1'b0;
    @(posedge clk); #1;                          // E+1
    chk("mid_touch0", {24'd0, ta0}, 32'd64);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;                          // E+2
    chk("mid_touch", {ta3, ta2, ta1, ta0}, 32'd0);
    chk("mid_overrun", {31'd0, ovr_a}, 32'd0);
    chk("mid_valid", {31'd0, valid_a}, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (6) @(posedge clk);
    frame_a({8'd128, 8'd128, 8'd128, 8'd64});

    // Slew-limited ramp up to 200, then down toward 0.
    jack = 8'h0F;
    in0 = 16'h3200; in1 = 16'h0000; in2 = 16'h0000; in3 = 16'h0000;
    for (int k = 1; k <= 13; k++) begin
      exp_b = (k == 13) ? 8'd200 : 8'(16 * k);
      frame_b(exp_b);
    end
    in0 = 16'h0000;
    for (int k = 1; k <= 4; k++) begin
      exp_b = 8'(200 - 16 * k);
      frame_b(exp_b);
    end

    repeat (4) @(posedge clk);
    chk("queue_a_drained", 32'(q_a.size()), 32'd0);
    chk("queue_b_drained", 32'(q_b.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
